// File: rtl/packetizer_nch.sv
// packetizer_nch: packs N_CH samples into 64-bit words, frames them as packets
// behind a store-and-forward FIFO. Define PACKETIZER_CHECKSUM_EN for an XOR trailer.
module packetizer_nch #(
    parameter int N_CH          = 2,
    parameter int SAMPLE_W      = 16,
    parameter int WORDS_PER_PKT = 1024,
    parameter int FIFO_DEPTH    = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     arm,
    input  logic                     sync_in,
    input  logic [N_CH*SAMPLE_W-1:0] samples_in,
    output logic [63:0]              tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     tx_eof,
    output logic                     running,
    output logic                     overflow,
    output logic [15:0]              drop_count
);
    localparam int SW = N_CH * SAMPLE_W;
    localparam int B  = 64 / SW;
`ifdef PACKETIZER_CHECKSUM_EN
    localparam int PKT_LEN = WORDS_PER_PKT + 2;
`else
    localparam int PKT_LEN = WORDS_PER_PKT + 1;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam int WW = $clog2(PKT_LEN + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LEN_C     = CW'(PKT_LEN);
    localparam logic [BW-1:0] BEAT_LAST = BW'(B - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_PKT - 1);
    localparam logic [WW-1:0] RD_LAST   = WW'(PKT_LEN - 1);

    typedef enum logic [1:0] {WAIT_ARM, WAIT_SYNC, RUNNING} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [WW-1:0] word_q, word_d;
    logic          keep_q, keep_d;
    logic [63:0]   acc_q, acc_d;
    logic [63:0]   seq_q, seq_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, cpkt_q, cpkt_d;
    logic [WW-1:0] rd_idx_q, rd_idx_d;
    logic [63:0]   tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d, tx_eof_q, tx_eof_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drops_q, drops_d;
    logic [63:0]   mem_q [FIFO_DEPTH];

    logic          take, pkt_start, fits, keep_now, word_done, last_word;
    logic [63:0]   word_val, trailer, wr0_data, wr1_data;
    logic          trl_wr, wr0_en, wr1_en, commit, ld, eof_hs, start_ok;

    // Capture FSM: arm, then sync, then run until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_ARM:  if (arm) state_d = WAIT_SYNC;
            WAIT_SYNC: if (sync_in) state_d = RUNNING;
            RUNNING:   state_d = RUNNING;
            default:   state_d = WAIT_ARM;
        endcase
    end

    // Beat/packet position decode and the word being assembled.
    always_comb begin
        take      = (state_q == RUNNING) && ce;
        pkt_start = take && (beat_q == '0) && (word_q == '0);
        fits      = (DEPTH_C - count_q) >= LEN_C;
        keep_now  = pkt_start ? fits : keep_q;
        word_done = take && (beat_q == BEAT_LAST);
        last_word = word_done && (word_q == WORD_LAST);
        word_val  = (acc_q << SW) | 64'(samples_in);
    end

`ifdef PACKETIZER_CHECKSUM_EN
    logic [63:0] csum_q, csum_d, csum_base;

    // XOR of the current packet's data words; trailer includes the last one.
    always_comb begin
        csum_base = pkt_start ? 64'd0 : csum_q;
        csum_d    = word_done ? (csum_base ^ word_val) : csum_base;
        trailer   = csum_base ^ word_val;
        trl_wr    = last_word && keep_now;
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end
`else
    // No trailer word in this build.
    always_comb begin
        trailer = 64'd0;
        trl_wr  = 1'b0;
    end
`endif

    // Write side: header/data/trailer go to up to two FIFO slots per cycle.
    always_comb begin
        wr0_en     = (pkt_start && fits) || (word_done && keep_now);
        wr0_data   = (pkt_start && fits) ? seq_q : word_val;
        wr1_en     = (pkt_start && fits && word_done) || (word_done && keep_now && trl_wr);
        wr1_data   = (pkt_start && fits) ? word_val : trailer;
        commit     = last_word && keep_now;
        acc_d      = take ? word_val : acc_q;
        beat_d     = beat_q;
        word_d     = word_q;
        keep_d     = keep_now;
        seq_d      = pkt_start ? seq_q + 64'd1 : seq_q;
        overflow_d = overflow_q || (pkt_start && !fits);
        drops_d    = drops_q;
        if (take) beat_d = word_done ? '0 : beat_q + BW'(1);
        if (word_done) word_d = last_word ? '0 : word_q + WW'(1);
        if (pkt_start && !fits && drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
        wr_ptr_d = wr_ptr_q + AW'(wr0_en) + AW'(wr1_en);
    end

    // Read side: registered output, whole committed packets only.
    always_comb begin
        start_ok   = cpkt_q > CW'(tx_valid_q & tx_eof_q);
        ld         = (!tx_valid_q || tx_ready) && ((rd_idx_q != '0) || start_ok);
        eof_hs     = tx_valid_q && tx_ready && tx_eof_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_eof_d   = tx_eof_q;
        rd_ptr_d   = rd_ptr_q;
        rd_idx_d   = rd_idx_q;
        if (ld) begin
            tx_data_d  = mem_q[rd_ptr_q];
            tx_valid_d = 1'b1;
            tx_eof_d   = (rd_idx_q == RD_LAST);
            rd_ptr_d   = rd_ptr_q + AW'(1);
            rd_idx_d   = (rd_idx_q == RD_LAST) ? '0 : rd_idx_q + WW'(1);
        end else if (tx_ready) begin
            tx_data_d  = 64'd0;
            tx_valid_d = 1'b0;
            tx_eof_d   = 1'b0;
        end
        count_d = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(ld);
        cpkt_d  = cpkt_q + CW'(commit) - CW'(eof_hs);
    end

    // FIFO storage; pointers carry all state, so no reset here.
    always_ff @(posedge clk) begin
        if (wr0_en) mem_q[wr_ptr_q] <= wr0_data;
        if (wr1_en) mem_q[wr_ptr_q + AW'(1)] <= wr1_data;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_ARM;
            beat_q     <= '0;
            word_q     <= '0;
            keep_q     <= 1'b0;
            acc_q      <= '0;
            seq_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cpkt_q     <= '0;
            rd_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_eof_q   <= 1'b0;
            overflow_q <= 1'b0;
            drops_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            keep_q     <= keep_d;
            acc_q      <= acc_d;
            seq_q      <= seq_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cpkt_q     <= cpkt_d;
            rd_idx_q   <= rd_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_eof_q   <= tx_eof_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_eof     = tx_eof_q;
    assign running    = (state_q == RUNNING);
    assign overflow   = overflow_q;
    assign drop_count = drops_q;
endmodule

// File: tb/tb_packetizer_nch.sv
// tb_packetizer_nch: scoreboard bench; a 2x16 and a 4x8 instance share stimulus
// and must both reproduce the reference packet stream.
`timescale 1ns/1ps
module tb_packetizer_nch;
    localparam int WPP   = 4;
    localparam int DEPTH = 16;
`ifdef PACKETIZER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int LEN = CSUM ? WPP + 2 : WPP + 1;

    logic        clk = 1'b0;
    logic        rst, ce, arm, sync_in, tx_ready;
    logic [31:0] samples;
    logic [63:0] d_a, d_b;
    logic        v_a, v_b, e_a, e_b, run_a, run_b, ov_a, ov_b;
    logic [15:0] dc_a, dc_b;

    always #5 clk = ~clk;

    packetizer_nch #(.N_CH(2), .SAMPLE_W(16), .WORDS_PER_PKT(WPP), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .arm(arm), .sync_in(sync_in),
        .samples_in(samples), .tx_data(d_a), .tx_valid(v_a), .tx_ready(tx_ready),
        .tx_eof(e_a), .running(run_a), .overflow(ov_a), .drop_count(dc_a));

    packetizer_nch #(.N_CH(4), .SAMPLE_W(8), .WORDS_PER_PKT(WPP), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .arm(arm), .sync_in(sync_in),
        .samples_in(samples), .tx_data(d_b), .tx_valid(v_b), .tx_ready(tx_ready),
        .tx_eof(e_b), .running(run_b), .overflow(ov_b), .drop_count(dc_b));

    int n_chk = 0;
    int n_fail = 0;
    logic [64:0] qa[$];
    logic [64:0] qb[$];
    bit          prev_h [2];
    logic [65:0] prev_w [2];

    // Reference model state
    int          m_st, m_beat, m_word, m_drops, m_occ, kk;
    bit          m_keep, m_pend, m_loaded, ovf_mode, rdy_lfsr;
    logic [63:0] m_seq, m_acc, m_csum;
    logic [15:0] lfsr = 16'hACE1;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [64:0] x);
        qa.push_back(x);
        qb.push_back(x);
    endtask

    task automatic pop_exp(input int id, output bit ok, output logic [64:0] x);
        ok = 1'b0;
        x = '0;
        if (id == 0) begin
            if (qa.size() > 0) begin x = qa.pop_front(); ok = 1'b1; end
        end else begin
            if (qb.size() > 0) begin x = qb.pop_front(); ok = 1'b1; end
        end
    endtask

    task automatic mon(input int id, input logic v, input logic e, input logic [63:0] d);
        bit ok;
        logic [64:0] x;
        if (prev_h[id]) check($sformatf("hold%0d", id), {v, e, d}, prev_w[id]);
        prev_h[id] = v && !tx_ready;
        prev_w[id] = {v, e, d};
        if (v && tx_ready) begin
            pop_exp(id, ok, x);
            if (!ok) check($sformatf("extra%0d", id), {1'b1, e, d}, 66'd0);
            else     check($sformatf("beat%0d", id), {1'b1, e, d}, {1'b1, x});
        end
    endtask

    // Output monitor, sampling on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_h[0] = 1'b0;
                prev_h[1] = 1'b0;
            end else begin
                mon(0, v_a, e_a, d_a);
                mon(1, v_b, e_b, d_b);
            end
        end
    end

    task automatic model_step(input bit take, input logic [31:0] s);
        logic [63:0] w;
        if (!take) return;
        if (m_beat == 0 && m_word == 0) begin
            m_keep = 1'b1;
            if (ovf_mode) begin
                m_keep = (DEPTH - m_occ) >= LEN;
                if (m_keep) m_occ += LEN;
                if (m_pend) begin m_occ -= 1; m_pend = 1'b0; end
                if (m_keep && !m_loaded) begin m_loaded = 1'b1; m_pend = 1'b1; end
            end
            if (!m_keep) m_drops++;
            if (m_keep) push({1'b0, m_seq});
            m_seq = m_seq + 64'd1;
            m_csum = '0;
        end
        m_acc = {m_acc[31:0], s};
        if (m_beat == 1) begin
            w = m_acc;
            m_csum ^= w;
            m_beat = 0;
            if (m_keep) push({!CSUM && (m_word == WPP - 1), w});
            if (m_word == WPP - 1) begin
                if (CSUM && m_keep) push({1'b1, m_csum});
                m_word = 0;
            end else begin
                m_word++;
            end
        end else begin
            m_beat = 1;
        end
    endtask

    task automatic cyc(input logic c, input logic [31:0] s, input logic a, input logic sy);
        ce = c;
        samples = s;
        arm = a;
        sync_in = sy;
        if (rdy_lfsr) begin
            tx_ready = lfsr[0];
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
        model_step(c && m_st == 2, s);
        if (m_st == 0 && a) m_st = 1;
        else if (m_st == 1 && sy) m_st = 2;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        ce = 1'b0;
        arm = 1'b0;
        sync_in = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
        qa.delete();
        qb.delete();
        m_st = 0; m_beat = 0; m_word = 0; m_drops = 0; m_occ = 0;
        m_keep = 1'b0; m_pend = 1'b0; m_loaded = 1'b0;
        m_seq = '0; m_acc = '0; m_csum = '0;
        rst = 1'b0;
    endtask

    task automatic send_beats(input int n, input int period, input bit bytes);
        logic [31:0] s;
        for (int i = 0; i < n; i++) begin
            if (bytes) s = {8'(4 * kk), 8'(4 * kk + 1), 8'(4 * kk + 2), 8'(4 * kk + 3)};
            else       s = {16'(2 * kk), 16'(2 * kk + 1)};
            kk++;
            cyc(1'b1, s, 1'b0, 1'b0);
            for (int j = 1; j < period; j++) cyc(1'b0, $urandom(), 1'b0, 1'b0);
        end
    endtask

    task automatic arm_sync();
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((qa.size() != 0 || qb.size() != 0) && i < 2000) begin
            cyc(1'b0, $urandom(), 1'b0, 1'b0);
            i++;
        end
        check("drain_a", 66'(qa.size()), 66'd0);
        check("drain_b", 66'(qb.size()), 66'd0);
        repeat (10) cyc(1'b0, $urandom(), 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst = 1'b1; ce = 1'b0; arm = 1'b0; sync_in = 1'b0;
        samples = '0; tx_ready = 1'b0; rdy_lfsr = 1'b0; ovf_mode = 1'b0; kk = 0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_data", 66'(d_a), 66'd0);
        check("rst_valid", 66'(v_a), 66'd0);
        check("rst_eof", 66'(e_a), 66'd0);
        check("rst_running", 66'(run_a), 66'd0);
        check("rst_overflow", 66'(ov_a), 66'd0);
        check("rst_drops", 66'(dc_a), 66'd0);
        check("rst_b", {v_b, e_b, d_b}, 66'd0);
        do_reset(1);

        // Arm/sync ordering, then framing with tx_ready held high
        tx_ready = 1'b1;
        repeat (3) cyc(1'b1, $urandom(), 1'b0, 1'b1);
        check("sync_no_arm", 66'({run_a, run_b}), 66'd0);
        cyc(1'b1, $urandom(), 1'b1, 1'b1);
        repeat (3) cyc(1'b1, $urandom(), 1'b0, 1'b0);
        check("wait_sync", 66'({run_a, run_b}), 66'd0);
        cyc(1'b1, $urandom(), 1'b0, 1'b1);
        check("running", 66'({run_a, run_b}), 66'd3);
        send_beats(2 * 2 * WPP, 1, 1'b0);
        drain();

        // Random backpressure
        do_reset(2);
        rdy_lfsr = 1'b1;
        arm_sync();
        send_beats(2 * 2 * WPP, 1, 1'b0);
        drain();
        rdy_lfsr = 1'b0;

        // Reset in the middle of a packet while output is stalled
        do_reset(2);
        tx_ready = 1'b0;
        arm_sync();
        send_beats(2 * WPP + 4, 1, 1'b0);
        repeat (3) cyc(1'b0, $urandom(), 1'b0, 1'b0);
        check("stall_valid", 66'({v_a, v_b}), 66'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out", {v_a, e_a, d_a}, 66'd0);
        check("midrst_b", {v_b, run_a, run_b}, 66'd0);
        do_reset(1);
        tx_ready = 1'b1;
        arm_sync();
        send_beats(2 * WPP, 1, 1'b0);
        lat = 0;
        while (!v_a && lat < 5) begin
            cyc(1'b0, $urandom(), 1'b0, 1'b0);
            lat++;
        end
        check("latency", 66'(v_a && lat <= 3), 66'd1);
        drain();

        // ce every third cycle, byte-lane ramp
        send_beats(2 * 2 * WPP, 3, 1'b1);
        drain();

        // Overflow: six packets into a stalled 16-word FIFO
        do_reset(2);
        tx_ready = 1'b0;
        arm_sync();
        ovf_mode = 1'b1;
        send_beats(6 * 2 * WPP, 1, 1'b0);
        ovf_mode = 1'b0;
        repeat (3) cyc(1'b0, $urandom(), 1'b0, 1'b0);
        check("ovf_flag", 66'({ov_a, ov_b}), 66'd3);
        check("drops_a", 66'(dc_a), 66'(m_drops));
        check("drops_b", 66'(dc_b), 66'(m_drops));
        tx_ready = 1'b1;
        repeat (30) cyc(1'b0, $urandom(), 1'b0, 1'b0);
        send_beats(2 * WPP, 1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
